// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit adder/accumulator with valid/ready handshake and STAGES result slots.
// Optional macro ADDER_PIPE_SAT_EN: saturate the accumulator instead of wrapping.
module adder_pipe_nbit #(
  parameter int N      = 10,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  input  logic         acc_clr,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N:0]   sum,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ovf_q;
  logic [STAGES-1:0] adv;
  logic [N:0]        sum_q [STAGES];
  logic [N:0]        acc_q;

  logic              accept;
  logic              blocked;
  logic [N:0]        acc_base;
  logic [N+1:0]      acc_raw;
  logic [N:0]        acc_nxt;
  logic [N:0]        res_sum;
  logic              res_ovf;

  // A slot is blocked only if it and every slot downstream are full with the sink stalled.
  always_comb begin
    blocked = ~out_ready;
    adv     = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      blocked = blocked & vld_q[i];
      adv[i]  = ~blocked;
    end
  end

  assign in_ready = adv[0] & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    acc_raw  = {1'b0, acc_base} + {2'b00, a};
`ifdef ADDER_PIPE_SAT_EN
    acc_nxt  = acc_raw[N+1] ? '1 : acc_raw[N:0];
`else
    acc_nxt  = acc_raw[N:0];
`endif
    res_sum  = mode ? acc_nxt : ({1'b0, a} + {1'b0, b});
    res_ovf  = mode & acc_raw[N+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < STAGES; i++) sum_q[i] <= '0;
    end else begin
      if (accept) begin
        if (mode)         acc_q <= acc_nxt;
        else if (acc_clr) acc_q <= '0;
      end
      if (adv[0]) begin
        vld_q[0] <= accept;
        sum_q[0] <= res_sum;
        ovf_q[0] <= res_ovf;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_q[i] <= vld_q[i-1];
          sum_q[i] <= sum_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the first edge.
  assign out_valid = vld_q[STAGES-1] & ~rst;
  assign sum       = rst ? '0 : sum_q[STAGES-1];
  assign ovf       = ~rst & ovf_q[STAGES-1];

endmodule
